// File: rtl/sync_buffer_reader_pkg.sv
// Shared types and constants for the quad-buffer read-side consumer.
package sync_buffer_reader_pkg;

  localparam int unsigned LOG_LEN_W = 5;
  localparam int unsigned LEN_W     = 23;
  localparam int unsigned BEAT_W    = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_SWAP,
    ST_XFER,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_ADDR,
    ENG_DATA
  } eng_state_t;

  // Exact log2 of a power of two; used for arsize and burst strides.
  function automatic int unsigned log2_int(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) == value) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_buffer_reader_if.sv
// AXI4 read channel plus AXI4-Stream output bundle for the buffer reader.
interface sync_buffer_reader_if #(
  parameter int unsigned MM_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic [MM_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]               m_axi_arlen;
  logic [2:0]               m_axi_arsize;
  logic [1:0]               m_axi_arburst;
  logic                     m_axi_arvalid;
  logic                     m_axi_arready;
  logic [DATA_WIDTH-1:0]    m_axi_rdata;
  logic                     m_axi_rlast;
  logic                     m_axi_rvalid;
  logic                     m_axi_rready;
  logic [DATA_WIDTH-1:0]    m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/sync_buffer_reader_axi_read_burst_ctrl.sv
// Single-outstanding AXI4 read burst engine with zero-latency R-to-stream forwarding.
module axi_read_burst_ctrl
  import sync_buffer_reader_pkg::*;
#(
  parameter int unsigned MM_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_launch,
  input  logic                     i_last_burst,
  input  logic [MM_ADDR_WIDTH-1:0] i_araddr,
  input  logic [BEAT_W-1:0]        i_beats_m1,
  output logic                     o_burst_end_c,
  output logic                     o_protocol_error,
  sync_buffer_reader_if.master     bus
);
  localparam logic [2:0] ARSIZE = 3'(log2_int(DATA_WIDTH / 8));

  eng_state_t         r_state, w_next;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_perr;
  logic               w_arvalid, w_rready, w_tvalid, w_tlast, w_in_data;
  logic               w_r_fire, w_beat_last;

  assign w_beat_last = (r_beat == i_beats_m1);
  assign w_r_fire    = w_rready & bus.m_axi_rvalid;

  always_comb begin
    w_next        = r_state;
    w_arvalid     = 1'b0;
    w_rready      = 1'b0;
    w_tvalid      = 1'b0;
    w_tlast       = 1'b0;
    w_in_data     = 1'b0;
    o_burst_end_c = 1'b0;
    case (r_state)
      ENG_IDLE: if (i_launch) w_next = ENG_ADDR;
      ENG_ADDR: begin
        w_arvalid = 1'b1;
        if (bus.m_axi_arready) w_next = ENG_DATA;
      end
      ENG_DATA: begin
        w_in_data = 1'b1;
        w_rready  = bus.m_axis_tready;
        w_tvalid  = bus.m_axi_rvalid;
        w_tlast   = i_last_burst & w_beat_last;
        // Beat count, not rlast, decides where the burst ends.
        if (bus.m_axi_rvalid && bus.m_axis_tready && w_beat_last) begin
          o_burst_end_c = 1'b1;
          w_next        = i_last_burst ? ENG_IDLE : ENG_ADDR;
        end
      end
      default: w_next = ENG_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ENG_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat <= '0;
      r_perr <= 1'b0;
    end else if (r_state == ENG_ADDR) begin
      r_beat <= '0;
    end else if (w_r_fire) begin
      r_beat <= r_beat + BEAT_W'(1);
      if (bus.m_axi_rlast != w_beat_last) r_perr <= 1'b1;
    end
  end

  assign o_protocol_error  = r_perr;
  assign bus.m_axi_araddr  = i_araddr;
  assign bus.m_axi_arlen   = i_beats_m1;
  assign bus.m_axi_arsize  = ARSIZE;
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arvalid = w_arvalid;
  assign bus.m_axi_rready  = w_rready;
  assign bus.m_axis_tvalid = w_tvalid;
  assign bus.m_axis_tlast  = w_tlast;
  assign bus.m_axis_tdata  = w_in_data ? bus.m_axi_rdata : '0;

endmodule

// File: rtl/sync_buffer_reader.sv
// Claims the latest completed buffer from the sync manager and streams it out of DDR.
module sync_buffer_reader
  import sync_buffer_reader_pkg::*;
#(
  parameter int unsigned MM_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BURST_LEN     = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     protocol_error,
  output logic                     SM_request,
  input  logic [LOG_LEN_W-1:0]     SM_log_length,
  input  logic [MM_ADDR_WIDTH-1:0] SM_read_buffer,
  sync_buffer_reader_if.master     bus
);
  localparam int unsigned LOG_BURST = log2_int(BURST_LEN);
  localparam int unsigned SIZE_LOG  = log2_int(DATA_WIDTH / 8);

  state_t                   r_state, w_next;
  logic [LOG_LEN_W-1:0]     r_log_b, w_log_b;
  logic [BEAT_W-1:0]        r_beats_m1;
  logic [LEN_W-1:0]         r_nburst_m1, r_burst_idx;
  logic [MM_ADDR_WIDTH-1:0] r_base, w_araddr;
  logic                     w_last_burst, w_burst_end, w_launch;

  assign w_log_b = (SM_log_length < LOG_LEN_W'(LOG_BURST)) ? SM_log_length
                                                           : LOG_LEN_W'(LOG_BURST);
  assign w_last_burst = (r_burst_idx == r_nburst_m1);
  // Each burst covers B words, so the stride is B * bytes-per-word.
  assign w_araddr = r_base + (MM_ADDR_WIDTH'(r_burst_idx) << (r_log_b + LOG_LEN_W'(SIZE_LOG)));

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    SM_request = 1'b0;
    w_launch   = 1'b0;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_REQUEST;
      ST_REQUEST: begin
        busy       = 1'b1;
        SM_request = 1'b1;
        w_next     = ST_SWAP;
      end
      ST_SWAP: begin
        busy     = 1'b1;
        w_launch = 1'b1;
        w_next   = ST_XFER;
      end
      ST_XFER: begin
        busy = 1'b1;
        if (w_burst_end && w_last_burst) w_next = ST_DONE;
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_log_b     <= '0;
      r_beats_m1  <= '0;
      r_nburst_m1 <= '0;
      r_base      <= '0;
      r_burst_idx <= '0;
    end else begin
      if (r_state == ST_REQUEST) begin
        r_log_b     <= w_log_b;
        r_beats_m1  <= BEAT_W'((LEN_W'(1) << w_log_b) - LEN_W'(1));
        r_nburst_m1 <= (LEN_W'(1) << (SM_log_length - w_log_b)) - LEN_W'(1);
      end
      if (r_state == ST_SWAP) begin
        r_base      <= SM_read_buffer;
        r_burst_idx <= '0;
      end else if (w_burst_end && !w_last_burst) begin
        r_burst_idx <= r_burst_idx + LEN_W'(1);
      end
    end
  end

  axi_read_burst_ctrl #(
    .MM_ADDR_WIDTH(MM_ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_burst (
    .i_clk           (aclk),
    .i_rst           (areset),
    .i_launch        (w_launch),
    .i_last_burst    (w_last_burst),
    .i_araddr        (w_araddr),
    .i_beats_m1      (r_beats_m1),
    .o_burst_end_c   (w_burst_end),
    .o_protocol_error(protocol_error),
    .bus             (bus)
  );

endmodule

// File: tb/tb_sync_buffer_reader.sv
// Directed bench: AXI read slave and stream sink models around sync_buffer_reader.
module tb_sync_buffer_reader;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 16;

  logic          aclk = 1'b0;
  logic          areset, start, busy, done, protocol_error, SM_request;
  logic [4:0]    SM_log_length;
  logic [AW-1:0] SM_read_buffer;

  sync_buffer_reader_if #(.MM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sync_buffer_reader #(.MM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .protocol_error(protocol_error),
    .SM_request    (SM_request),
    .SM_log_length (SM_log_length),
    .SM_read_buffer(SM_read_buffer),
    .bus           (bus)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] rx_data[$];
  logic        rx_last[$];
  logic [31:0] ar_addr[$];
  logic [7:0]  ar_len[$];
  int          req_cycles, done_cnt, done_cyc, last_beat_cyc, mirror_bad, ar_unstable;
  logic        prev_ar_wait = 1'b0;
  logic [31:0] prev_araddr;
  logic [7:0]  prev_arlen;

  logic gaps   = 1'b0;
  logic inject = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Observer: everything sampled on the falling edge, away from the active edge.
  initial forever begin
    @(negedge aclk);
    cyc++;
    if (!areset) begin
      if (SM_request) req_cycles++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.m_axis_tvalid && (bus.m_axi_rready !== bus.m_axis_tready)) mirror_bad++;
      if (prev_ar_wait && (!bus.m_axi_arvalid || bus.m_axi_araddr !== prev_araddr ||
                           bus.m_axi_arlen !== prev_arlen)) ar_unstable++;
      prev_ar_wait = bus.m_axi_arvalid && !bus.m_axi_arready;
      prev_araddr  = bus.m_axi_araddr;
      prev_arlen   = bus.m_axi_arlen;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        ar_addr.push_back(bus.m_axi_araddr);
        ar_len.push_back(bus.m_axi_arlen);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        rx_data.push_back(bus.m_axis_tdata);
        rx_last.push_back(bus.m_axis_tlast);
        if (bus.m_axis_tlast) last_beat_cyc = cyc;
      end
    end else begin
      prev_ar_wait = 1'b0;
    end
  end

  // AXI read slave (data = word address) and stream sink.
  initial begin
    logic        have, ar_fire, r_fire, rst_seen;
    logic [31:0] s_addr, ar_a;
    int          s_beat, s_len;
    logic [7:0]  ar_l;
    have = 1'b0; s_addr = '0; s_beat = 0; s_len = 0;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
    bus.m_axi_rlast = 1'b0; bus.m_axis_tready = 1'b0;
    forever begin
      @(negedge aclk);
      ar_fire  = bus.m_axi_arvalid && bus.m_axi_arready;
      r_fire   = bus.m_axi_rvalid && bus.m_axi_rready;
      rst_seen = areset;
      ar_a     = bus.m_axi_araddr;
      ar_l     = bus.m_axi_arlen;
      @(posedge aclk);
      #1;
      if (rst_seen) have = 1'b0;
      else begin
        if (r_fire) begin
          if (s_beat == s_len) have = 1'b0;
          else s_beat++;
        end
        if (ar_fire) begin
          have = 1'b1; s_addr = ar_a; s_len = int'(ar_l); s_beat = 0;
        end
      end
      bus.m_axi_arready = gaps ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (!(have && bus.m_axi_rvalid && !r_fire))
        bus.m_axi_rvalid = have && (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
      bus.m_axi_rdata   = s_addr + 32'(4 * s_beat);
      bus.m_axi_rlast   = have && ((s_beat == s_len) || (inject && s_beat == 6));
      bus.m_axis_tready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic clear_obs;
    rx_data.delete(); rx_last.delete(); ar_addr.delete(); ar_len.delete();
    req_cycles = 0; done_cnt = 0; done_cyc = 0; last_beat_cyc = 0;
    mirror_bad = 0; ar_unstable = 0;
  endtask

  task automatic pulse_start;
    @(posedge aclk); #1 start = 1'b1;
    @(posedge aclk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge aclk);
      k++;
    end
    repeat (3) @(negedge aclk);
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_transfer(input string tag, input logic [31:0] base, input int words,
                                input int exp_nar, input logic [7:0] exp_len,
                                input logic [31:0] stride);
    int errs, nlast;
    check({tag, "_req_cycles"}, 64'(req_cycles), 64'd1);
    check({tag, "_n_ar"}, 64'(ar_addr.size()), 64'(exp_nar));
    for (int i = 0; i < ar_addr.size() && i < exp_nar; i++) begin
      check($sformatf("%s_araddr%0d", tag, i), 64'(ar_addr[i]), 64'(base + stride * 32'(i)));
      check($sformatf("%s_arlen%0d", tag, i), 64'(ar_len[i]), 64'(exp_len));
    end
    check({tag, "_beats"}, 64'(rx_data.size()), 64'(words));
    errs = 0; nlast = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== base + 32'(4 * i)) errs++;
      if (rx_last[i]) nlast++;
    end
    check({tag, "_data_errs"}, 64'(errs), 64'd0);
    check({tag, "_tlast_cnt"}, 64'(nlast), 64'd1);
    if (rx_last.size() > 0) check({tag, "_tlast_final"}, 64'(rx_last[rx_last.size()-1]), 64'd1);
    check({tag, "_done_lat"}, 64'(done_cyc - last_beat_cyc), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run_transfer(input string tag, input logic [4:0] lg, input logic [31:0] base,
                              input int exp_nar, input logic [7:0] exp_len);
    SM_log_length = lg; SM_read_buffer = base;
    clear_obs();
    pulse_start();
    wait_done(tag, 3000);
    check_transfer(tag, base, 1 << lg, exp_nar, exp_len, 32'h40);
  endtask

  initial begin
    int k;
    areset = 1'b1; start = 1'b0; SM_log_length = '0; SM_read_buffer = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_perr", 64'(protocol_error), 64'd0);
    check("rst_smreq", 64'(SM_request), 64'd0);
    check("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
    check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("rst_arsize", 64'(bus.m_axi_arsize), 64'd2);
    check("rst_arburst", 64'(bus.m_axi_arburst), 64'd1);
    @(posedge aclk); #1 areset = 1'b0;

    run_transfer("single", 5'd4, 32'h1000_0000, 1, 8'd15);
    run_transfer("multi", 5'd6, 32'h2000_0000, 4, 8'd15);
    run_transfer("short", 5'd2, 32'h3000_0100, 1, 8'd3);

    gaps = 1'b1;
    run_transfer("bp", 5'd5, 32'h4000_0000, 2, 8'd15);
    check("bp_rready_mirror", 64'(mirror_bad), 64'd0);
    check("bp_ar_stable", 64'(ar_unstable), 64'd0);
    gaps = 1'b0;
    check("pre_perr", 64'(protocol_error), 64'd0);

    // Early rlast on beat 7, plus a start pulse while busy.
    inject = 1'b1;
    SM_log_length = 5'd4; SM_read_buffer = 32'h5000_0000;
    clear_obs();
    pulse_start();
    repeat (8) @(posedge aclk);
    #1 start = 1'b1;
    @(posedge aclk); #1 start = 1'b0;
    wait_done("perr", 3000);
    inject = 1'b0;
    check_transfer("perr", 32'h5000_0000, 16, 1, 8'd15, 32'h40);
    check("perr_set", 64'(protocol_error), 64'd1);
    repeat (5) @(negedge aclk);
    check("perr_sticky", 64'(protocol_error), 64'd1);
    check("perr_no_restart", 64'(busy), 64'd0);

    // Reset in the middle of the data phase.
    SM_log_length = 5'd4; SM_read_buffer = 32'h6000_0000;
    clear_obs();
    pulse_start();
    k = 0;
    while (rx_data.size() < 5 && k < 200) begin
      @(posedge aclk); #1;
      k++;
    end
    check("rst_mid_reached", 64'(rx_data.size() >= 5), 64'd1);
    areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
    check("rst_mid_rready", 64'(bus.m_axi_rready), 64'd0);
    check("rst_mid_perr", 64'(protocol_error), 64'd0);

    run_transfer("post_rst", 5'd4, 32'h7000_0000, 1, 8'd15);
    check("post_rst_perr", 64'(protocol_error), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
